// File: rtl/dest_reg_scoreboard_pkg.sv
// Shared definitions for the destination-register scoreboard: forwarding
// select encodings, architectural register numbers and the in-flight entry.
package dest_reg_scoreboard_pkg;

   // Register-number width of an entry; the 32-bit pending mask ties it to 5.
   localparam int SB_REG_W = 5;

   localparam logic [1:0] FWD_NONE  = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   localparam logic [SB_REG_W-1:0] REG_ZERO = 5'd0;
   localparam logic [SB_REG_W-1:0] REG_RA   = 5'd31;

   typedef struct packed {
      logic                valid;
      logic                regwrite;
      logic                memread;
      logic [SB_REG_W-1:0] dest;
   } sb_entry_t;

   localparam sb_entry_t SB_BUBBLE = '0;

   // True when the entry will write register r; $zero is never a producer.
   function automatic logic writes_reg(sb_entry_t e, logic [SB_REG_W-1:0] r);
      return e.valid & e.regwrite & (e.dest == r) & (r != REG_ZERO);
   endfunction

endpackage

// File: rtl/dest_reg_scoreboard_match.sv
// Combinational compare of one in-flight entry against the ID sources.
module sb_match
   import dest_reg_scoreboard_pkg::*;
(
   input  sb_entry_t           entry,
   input  logic [SB_REG_W-1:0] rs,
   input  logic [SB_REG_W-1:0] rt,
   output logic                hit_rs,
   output logic                hit_rt
);

   assign hit_rs = writes_reg(entry, rs);
   assign hit_rt = writes_reg(entry, rt);

endmodule

// File: rtl/dest_reg_scoreboard.sv
// Destination-register scoreboard beside the ID/EX register: tracks the
// EX/MEM/WB producers, raises the ID stall and registers the EX operand
// forwarding selects for the instruction being issued.
module dest_reg_scoreboard
   import dest_reg_scoreboard_pkg::*;
#(
   parameter int REG_W      = SB_REG_W,
   parameter bit FORWARD_EN = 1'b1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             hold,
   input  logic             flush,
   output logic             stall_id,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [31:0]      pending,
   output logic [CNT_W-1:0] stall_cnt
);

   sb_entry_t        ex_reg, mem_reg, wb_reg, ex_next;
   logic             ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
   logic             wb_hit_rs, wb_hit_rt;
   logic             ex_used, mem_used, issue;
   logic [1:0]       fwd_a_reg, fwd_b_reg, fwd_a_next, fwd_b_next;
   logic [31:0]      pending_reg, pending_next;
   logic [CNT_W-1:0] stall_cnt_reg;
   logic             unused_wb_hit;

   sb_match u_match_ex (
      .entry (ex_reg),  .rs (id_rs), .rt (id_rt),
      .hit_rs(ex_hit_rs),  .hit_rt(ex_hit_rt)
   );
   sb_match u_match_mem (
      .entry (mem_reg), .rs (id_rs), .rt (id_rt),
      .hit_rs(mem_hit_rs), .hit_rt(mem_hit_rt)
   );
   sb_match u_match_wb (
      .entry (wb_reg),  .rs (id_rs), .rt (id_rt),
      .hit_rs(wb_hit_rs),  .hit_rt(wb_hit_rt)
   );

   // A WB producer is resolved by the write-then-read register file, so its
   // hits never stall or forward; they are only visible for debug probing.
   assign unused_wb_hit = wb_hit_rs | wb_hit_rt;

   assign ex_used  = (ex_hit_rs  & id_uses_rs) | (ex_hit_rt  & id_uses_rt);
   assign mem_used = (mem_hit_rs & id_uses_rs) | (mem_hit_rt & id_uses_rt);

   // Stall: load-use only when forwarding exists, else any EX/MEM RAW hazard.
   always_comb begin
      stall_id = 1'b0;
      if (id_valid && !flush) begin
         if (FORWARD_EN) stall_id = ex_reg.memread & ex_used;
         else            stall_id = ex_used | mem_used;
      end
   end

   assign issue = id_valid & ~flush & ~stall_id;

   // Record entering EX: the ID instruction on issue, otherwise a bubble.
   always_comb begin
      ex_next = SB_BUBBLE;
      if (issue) begin
         ex_next.valid    = 1'b1;
         ex_next.regwrite = id_regwrite;
         ex_next.memread  = id_memread;
         ex_next.dest     = id_dest;
      end
   end

   // Forward selects for the issuing instruction; the younger EX producer wins.
   always_comb begin
      fwd_a_next = FWD_NONE;
      fwd_b_next = FWD_NONE;
      if (FORWARD_EN && issue) begin
         if (ex_hit_rs && !ex_reg.memread) fwd_a_next = FWD_EXMEM;
         else if (mem_hit_rs)              fwd_a_next = FWD_MEMWB;
         if (ex_hit_rt && !ex_reg.memread) fwd_b_next = FWD_EXMEM;
         else if (mem_hit_rt)              fwd_b_next = FWD_MEMWB;
      end
   end

   // Pending mask from the entries that will occupy EX/MEM/WB after the edge.
   genvar gi;
   assign pending_next[0] = 1'b0;
   generate
      for (gi = 1; gi < 32; gi++) begin : g_pending
         assign pending_next[gi] = writes_reg(ex_next, SB_REG_W'(gi))
                                 | writes_reg(ex_reg,  SB_REG_W'(gi))
                                 | writes_reg(mem_reg, SB_REG_W'(gi));
      end
   endgenerate

   // Pipeline shift, registered outputs and saturating stall counter; hold freezes all.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_reg        <= SB_BUBBLE;
         mem_reg       <= SB_BUBBLE;
         wb_reg        <= SB_BUBBLE;
         fwd_a_reg     <= FWD_NONE;
         fwd_b_reg     <= FWD_NONE;
         pending_reg   <= '0;
         stall_cnt_reg <= '0;
      end else if (!hold) begin
         ex_reg      <= ex_next;
         mem_reg     <= ex_reg;
         wb_reg      <= mem_reg;
         fwd_a_reg   <= fwd_a_next;
         fwd_b_reg   <= fwd_b_next;
         pending_reg <= pending_next;
         if (stall_id && (stall_cnt_reg != {CNT_W{1'b1}}))
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
   end

   assign fwd_a     = fwd_a_reg;
   assign fwd_b     = fwd_b_reg;
   assign pending   = pending_reg;
   assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// Self-checking bench: a forwarding instance and a no-forwarding instance
// (3-bit counter, so saturation is reached) share the ID stimulus and are
// compared every cycle with a per-instance model of the in-flight records.
module tb_dest_reg_scoreboard;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       id_valid = 1'b0, id_uses_rs = 1'b0, id_uses_rt = 1'b0;
   logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
   logic       id_regwrite = 1'b0, id_memread = 1'b0, hold = 1'b0, flush = 1'b0;

   logic        stall1, stall0;
   logic [1:0]  fa1, fb1, fa0, fb0;
   logic [31:0] p1, p0;
   logic [15:0] c1;
   logic [2:0]  c0;

   dest_reg_scoreboard #(.FORWARD_EN(1'b1)) dut1 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .hold(hold), .flush(flush),
      .stall_id(stall1), .fwd_a(fa1), .fwd_b(fb1), .pending(p1), .stall_cnt(c1)
   );

   dest_reg_scoreboard #(.FORWARD_EN(1'b0), .CNT_W(3)) dut0 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .hold(hold), .flush(flush),
      .stall_id(stall0), .fwd_a(fa0), .fwd_b(fb0), .pending(p0), .stall_cnt(c0)
   );

   always #5 clk = ~clk;

   // Model: index m = FORWARD_EN value; pipe[m][0] is EX (youngest), [2] is WB.
   typedef struct { bit v; bit w; bit ld; int d; } rec_t;
   rec_t      pipe [2][3];
   int        fa_m [2];
   int        fb_m [2];
   int        cnt_m [2];
   bit [31:0] pend_m [2];
   int        cnt_max [2] = '{7, 65535};
   bit        last_stall [2];
   int        total = 0;
   int        bad = 0;
   int        n_step = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit produces(rec_t e, int r);
      return e.v && e.w && (e.d == r) && (r != 0);
   endfunction

   function automatic bit reads(int r);
      return (id_uses_rs && int'(id_rs) == r) || (id_uses_rt && int'(id_rt) == r);
   endfunction

   function automatic bit model_stall(int m);
      if (!id_valid || flush) return 1'b0;
      for (int s = 0; s < ((m == 1) ? 1 : 2); s++)
         if (produces(pipe[m][s], pipe[m][s].d) && reads(pipe[m][s].d) &&
             (m == 0 || pipe[m][s].ld))
            return 1'b1;
      return 1'b0;
   endfunction

   function automatic int model_fwd(int m, int r);
      if (m == 0) return 0;
      if (produces(pipe[m][0], r) && !pipe[m][0].ld) return 1;
      if (produces(pipe[m][1], r)) return 2;
      return 0;
   endfunction

   task automatic model_clear();
      for (int m = 0; m < 2; m++) begin
         for (int s = 0; s < 3; s++) pipe[m][s] = '{0, 0, 0, 0};
         fa_m[m] = 0; fb_m[m] = 0; cnt_m[m] = 0; pend_m[m] = '0;
      end
   endtask

   task automatic check_regs(string tag);
      chk({tag, "_fwd_a1"}, {30'd0, fa1}, fa_m[1]);
      chk({tag, "_fwd_b1"}, {30'd0, fb1}, fb_m[1]);
      chk({tag, "_pend1"},  p1, pend_m[1]);
      chk({tag, "_cnt1"},   {16'd0, c1}, cnt_m[1]);
      chk({tag, "_fwd_a0"}, {30'd0, fa0}, fa_m[0]);
      chk({tag, "_fwd_b0"}, {30'd0, fb0}, fb_m[0]);
      chk({tag, "_pend0"},  p0, pend_m[0]);
      chk({tag, "_cnt0"},   {29'd0, c0}, cnt_m[0]);
   endtask

   // One ID cycle: drive, check the stall, advance the model, clock, check registers.
   task automatic step(bit v, int rs, int rt, bit urs, bit urt, int dest,
                       bit rw, bit mr, bit hd, bit fl);
      bit st [2];
      bit issue;
      id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs; id_uses_rt = urt;
      id_dest = 5'(dest); id_regwrite = rw; id_memread = mr; hold = hd; flush = fl;
      #1;
      st[0] = model_stall(0);
      st[1] = model_stall(1);
      last_stall[0] = stall0;
      last_stall[1] = stall1;
      chk("stall1", {31'd0, stall1}, {31'd0, st[1]});
      chk("stall0", {31'd0, stall0}, {31'd0, st[0]});
      for (int m = 0; m < 2; m++) begin
         if (!hd) begin
            issue = v && !fl && !st[m];
            fa_m[m] = issue ? model_fwd(m, rs) : 0;
            fb_m[m] = issue ? model_fwd(m, rt) : 0;
            pipe[m][2] = pipe[m][1];
            pipe[m][1] = pipe[m][0];
            pipe[m][0].v = issue;
            pipe[m][0].w = issue && rw;
            pipe[m][0].ld = issue && mr;
            pipe[m][0].d = issue ? dest : 0;
            pend_m[m] = '0;
            for (int s = 0; s < 3; s++)
               if (produces(pipe[m][s], pipe[m][s].d)) pend_m[m][pipe[m][s].d] = 1'b1;
            if (st[m] && cnt_m[m] < cnt_max[m]) cnt_m[m]++;
         end
      end
      @(posedge clk);
      #1;
      check_regs("step");
      n_step++;
      $display("step %0d v=%0b rs=%0d rt=%0d use=%0b%0b dest=%0d rw=%0b ld=%0b hold=%0b flush=%0b stall=%0b/%0b fwd1=%0d,%0d fwd0=%0d,%0d pend1=%08h cnt=%0d/%0d",
               n_step, v, rs, rt, urs, urt, dest, rw, mr, hd, fl, stall1, stall0,
               fa1, fb1, fa0, fb0, p1, c1, c0);
   endtask

   // Reset with whatever ID/hold inputs are currently driven; reset must win.
   task automatic do_reset(string tag);
      reset = 1'b1;
      @(posedge clk);
      #1;
      model_clear();
      check_regs(tag);
      chk({tag, "_stall1"}, {31'd0, stall1}, 32'd0);
      chk({tag, "_stall0"}, {31'd0, stall0}, 32'd0);
      reset = 1'b0;
      id_valid = 1'b0; hold = 1'b0; flush = 1'b0;
      $display("reset %s", tag);
   endtask

   initial begin
      model_clear();
      do_reset("rst0");

      // R-type dest 8, consumer rs=8 then consumer rt=8.
      step(1, 1, 2, 1, 1, 8, 1, 0, 0, 0);
      step(1, 8, 3, 1, 1, 10, 1, 0, 0, 0);
      chk("p1_stall", {31'd0, last_stall[1]}, 32'd0);
      chk("p1_fwd_a", {30'd0, fa1}, 32'd1);
      step(1, 4, 8, 1, 1, 11, 1, 0, 0, 0);
      chk("p1_fwd_b", {30'd0, fb1}, 32'd2);

      // Load dest 9, consumer rt=9 held in ID across the one-cycle stall.
      do_reset("rst1");
      step(1, 1, 2, 1, 1, 9, 1, 1, 0, 0);
      step(1, 3, 9, 1, 1, 12, 1, 0, 0, 0);
      chk("p2_stall_on", {31'd0, last_stall[1]}, 32'd1);
      step(1, 3, 9, 1, 1, 12, 1, 0, 0, 0);
      chk("p2_stall_off", {31'd0, last_stall[1]}, 32'd0);
      chk("p2_fwd_b", {30'd0, fb1}, 32'd2);
      chk("p2_cnt", {16'd0, c1}, 32'd1);

      // Writes to $zero never hazard, forward or set pending.
      do_reset("rst2");
      step(1, 1, 2, 1, 1, 0, 1, 0, 0, 0);
      step(1, 0, 5, 1, 1, 6, 1, 0, 0, 0);
      chk("p3_fwd_a", {30'd0, fa1}, 32'd0);
      chk("p3_pend0", {31'd0, p1[0]}, 32'd0);

      // Load-use hazard flushed in the same cycle.
      do_reset("rst3");
      step(1, 1, 2, 1, 1, 12, 1, 1, 0, 0);
      step(1, 12, 2, 1, 1, 13, 1, 0, 0, 1);
      chk("p4_stall", {31'd0, last_stall[1]}, 32'd0);
      chk("p4_cnt", {16'd0, c1}, 32'd0);
      chk("p4_pend", p1, 32'h0000_1000);

      // Three-cycle hold with EX=6, MEM=4, WB=3, then resume.
      do_reset("rst4");
      step(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
      step(1, 1, 2, 1, 1, 4, 1, 0, 0, 0);
      step(1, 1, 2, 1, 1, 6, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 6, 4, 1, 1, 7, 1, 0, 1, 0);
         chk("p5_hold_pend", p1, 32'h0000_0058);
         chk("p5_hold_fwd_a", {30'd0, fa1}, 32'd0);
      end
      step(1, 6, 4, 1, 1, 7, 1, 0, 0, 0);
      chk("p5_fwd_a", {30'd0, fa1}, 32'd1);
      chk("p5_fwd_b", {30'd0, fb1}, 32'd2);
      chk("p5_pend", p1, 32'h0000_00d0);

      // No forwarding: producer dest 5 stalls its consumer for two cycles.
      do_reset("rst5");
      step(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
      step(1, 5, 0, 1, 0, 14, 1, 0, 0, 0);
      chk("p6_stall_a", {31'd0, last_stall[0]}, 32'd1);
      step(1, 5, 0, 1, 0, 14, 1, 0, 0, 0);
      chk("p6_stall_b", {31'd0, last_stall[0]}, 32'd1);
      step(1, 5, 0, 1, 0, 14, 1, 0, 0, 0);
      chk("p6_issue", {31'd0, last_stall[0]}, 32'd0);
      chk("p6_fwd_a", {30'd0, fa0}, 32'd0);
      chk("p6_cnt", {29'd0, c0}, 32'd2);
      step(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
      step(1, 5, 0, 1, 0, 14, 1, 0, 0, 0);
      hold = 1'b1;
      do_reset("p6_midstall");

      // Randomised traffic over a small register range to provoke hazards.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            hold = $urandom_range(0, 1) == 1;
            do_reset("rand");
         end else begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 4) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
